// File: rtl/fifo_rx_reader.sv
// Drain stage of the SpaceWire RX FIFO: pops N-chars into a 2-entry host stream buffer
// and converts FIFO slot releases into FCT credits. Define RX_PKT_COUNT_EN to add pkt_count.
module fifo_rx_reader #(
    parameter int DWIDTH  = 9,
    parameter int POP_GAP = 3,
    parameter int MAX_FCT = 7,
    parameter int FCT_CW  = 3
`ifdef RX_PKT_COUNT_EN
    ,
    parameter int PKT_CW  = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              open_slot_fct,
    output logic              rd_en,
    output logic [DWIDTH-1:0] host_data,
    output logic              host_valid,
    input  logic              host_ready,
    output logic              host_eop,
    output logic              host_eep,
    output logic              fct_req,
    input  logic              fct_ack,
    output logic [FCT_CW-1:0] fct_pending,
    output logic              fct_err
`ifdef RX_PKT_COUNT_EN
    ,
    output logic [PKT_CW-1:0] pkt_count
`endif
);

    localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              eop;
        logic              eep;
    } entry_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    entry_t          buf_q [2];
    entry_t          buf_d [2];
    logic [1:0]      count_q, count_d;
    logic            open_slot_q, open_slot_d;
    logic [FCT_CW-1:0] pending_q, pending_d;
    logic            err_q, err_d;
    logic            capture;
    logic            pop;
    logic            rise;
    entry_t          new_entry;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!f_empty && count_q != 2'd2) begin
                    capture = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (POP_GAP > 1) begin
                    state_d = S_WAIT;
                    gap_d   = GW'(POP_GAP - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                gap_d = gap_q - GW'(1);
                if (gap_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en = (state_q == S_POP);

    // Unused tail entry is kept cleared, so a pop shifting it up also blanks an emptied head.
    always_comb begin
        new_entry.data = fifo_data;
        new_entry.eop  = fifo_data[DWIDTH-1] && (fifo_data[7:0] == 8'h00);
        new_entry.eep  = fifo_data[DWIDTH-1] && (fifo_data[7:0] == 8'h01);
        pop     = host_valid && host_ready;
        buf_d   = buf_q;
        count_d = count_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = '0;
            count_d  = count_q - 2'd1;
        end
        if (capture) begin
            if (count_d == 2'd0) begin
                buf_d[0] = new_entry;
            end else begin
                buf_d[1] = new_entry;
            end
            count_d = count_d + 2'd1;
        end
    end

    assign host_valid = (count_q != 2'd0);
    assign host_data  = buf_q[0].data;
    assign host_eop   = buf_q[0].eop;
    assign host_eep   = buf_q[0].eep;

    always_comb begin
        open_slot_d = open_slot_fct;
        rise        = open_slot_fct && !open_slot_q;
        pending_d   = pending_q;
        err_d       = err_q;
        if (rise && !fct_ack) begin
            if (pending_q == FCT_CW'(MAX_FCT)) begin
                err_d = 1'b1;
            end else begin
                pending_d = pending_q + FCT_CW'(1);
            end
        end else if (fct_ack && !rise && pending_q != '0) begin
            pending_d = pending_q - FCT_CW'(1);
        end
    end

    assign fct_pending = pending_q;
    assign fct_req     = (pending_q != '0);
    assign fct_err     = err_q;

    // The edge detector tracks the input even in reset, so a level already high is not a credit.
    always_ff @(posedge clock) begin
        open_slot_q <= open_slot_d;
        if (reset) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            count_q   <= 2'd0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

`ifdef RX_PKT_COUNT_EN
    logic [PKT_CW-1:0] pkt_q, pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        if (pop && (buf_q[0].eop || buf_q[0].eep)) begin
            pkt_d = pkt_q + PKT_CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign pkt_count = pkt_q;
`endif

endmodule
